spectral_band_filter: RTL and testbench

Parametrised frequency-domain band filter that streams one FFT frame out of the spectrum RAM and zeroes the bins outside a programmable band. It sits between the forward-FFT result RAM and the IFFT input stream, and generalises the fixed low-bin denoise separator. Additions over that separator:
- run-time mode and cut-off bins, applied symmetrically to the mirrored upper half of the spectrum;
- configurable frame size and RAM read latency;
- a full valid/ready handshake with backpressure.

---
 rtl/spectral_band_filter.sv | 162 ++++++++++++++++
 tb/tb_spectral_band_filter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectral_band_filter.sv
// Streams one FFT frame out of the spectrum RAM, zeroing bins whose mirrored
// frequency falls outside the band selected by mode/cut_lo/cut_hi.
`timescale 1ns/1ps
module spectral_band_filter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] cut_lo,
  input  logic [ADDR_W-1:0] cut_hi,
  output logic              busy,
  output logic              done,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] freq_data,
  output logic              freq_valid,
  output logic              freq_last,
  input  logic              freq_ready
);

  localparam int DEPTH = RAM_LAT + 1;
  localparam int PW    = (DEPTH > 2) ? 2 : 1;
  localparam int CW    = 3;
  localparam logic [ADDR_W-1:0] LAST_BIN = '1;
  localparam logic [ADDR_W-1:0] HALF     = {1'b1, {(ADDR_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] lo_q, hi_q;

  logic [RAM_LAT-1:0] rd_pipe;
  logic [ADDR_W-1:0]  idx_pipe [RAM_LAT];

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic              fifo_last [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic              push, pop, pass, can_issue;
  logic [ADDR_W-1:0] arr_idx, freq_bin;
  logic [CW:0]       in_flight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push       = rd_pipe[RAM_LAT-1];
  assign arr_idx    = idx_pipe[RAM_LAT-1];
  assign freq_valid = (count != '0);
  assign freq_data  = freq_valid ? fifo_data[rd_ptr] : '0;
  assign freq_last  = freq_valid & fifo_last[rd_ptr];
  assign pop        = freq_valid & freq_ready;

  // Upper half of the spectrum mirrors onto the lower half.
  assign freq_bin = (arr_idx <= HALF) ? arr_idx : ({ADDR_W{1'b0}} - arr_idx);

  always_comb begin
    pass = 1'b0;
    case (mode_q)
      2'b00:   pass = 1'b1;
      2'b01:   pass = (freq_bin <= lo_q);
      2'b10:   pass = (freq_bin >= hi_q);
      default: pass = (freq_bin >= lo_q) && (freq_bin <= hi_q);
    endcase
  end

  // A beat leaving the buffer this cycle frees its slot, keeping full rate.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LAT; i++)
      in_flight = in_flight + (CW+1)'(rd_pipe[i]);
  end

  assign can_issue = ({1'b0, count} + in_flight) < ((CW+1)'(DEPTH) + (CW+1)'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (ram_rd && (ram_addr == LAST_BIN)) state_nxt = FLUSH;
      FLUSH:   if (pop && freq_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    ram_rd = 1'b0;
    case (state)
      RUN:     begin busy = 1'b1; ram_rd = can_issue; end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 2'b00;
      lo_q     <= '0;
      hi_q     <= '0;
      ram_addr <= '0;
    end else if (state == IDLE && start) begin
      mode_q   <= mode;
      lo_q     <= cut_lo;
      hi_q     <= cut_hi;
      ram_addr <= '0;
    end else if (ram_rd && (ram_addr != LAST_BIN)) begin
      ram_addr <= ram_addr + ADDR_W'(1);
    end
  end

  // Bin index travels with each read so the filter sees it alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
      for (int i = 0; i < RAM_LAT; i++) idx_pipe[i] <= '0;
    end else begin
      rd_pipe[0]  <= ram_rd;
      idx_pipe[0] <= ram_addr;
      for (int i = 1; i < RAM_LAT; i++) begin
        rd_pipe[i]  <= rd_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= pass ? ram_data : '0;
        fifo_last[wr_ptr] <= (arr_idx == LAST_BIN);
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_spectral_band_filter.sv
// Directed bench for spectral_band_filter: two instances (RAM_LAT 1 and 3)
// sharing stimulus, each fed by a RAM model whose word k equals k.
`timescale 1ns/1ps
module tb_spectral_band_filter;

  localparam int N = 1024;

  logic       clk, rst_n, start_a, start_b, freq_ready;
  logic [1:0] mode;
  logic [9:0] cut_lo, cut_hi;

  logic        busy_a, done_a, ram_rd_a, freq_valid_a, freq_last_a;
  logic [9:0]  ram_addr_a;
  logic [31:0] ram_data_a, freq_data_a;
  logic        busy_b, done_b, ram_rd_b, freq_valid_b, freq_last_b;
  logic [9:0]  ram_addr_b;
  logic [31:0] ram_data_b, freq_data_b;

  logic        busy, done, ram_rd, freq_valid, freq_last;
  logic [9:0]  ram_addr;
  logic [31:0] freq_data;

  int          vectors, miscompares, sel;
  logic [31:0] got [N];

  spectral_band_filter #(.ADDR_W(10), .DATA_W(32), .RAM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode),
    .cut_lo(cut_lo), .cut_hi(cut_hi), .busy(busy_a), .done(done_a),
    .ram_rd(ram_rd_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
    .freq_data(freq_data_a), .freq_valid(freq_valid_a),
    .freq_last(freq_last_a), .freq_ready(freq_ready)
  );

  spectral_band_filter #(.ADDR_W(10), .DATA_W(32), .RAM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode),
    .cut_lo(cut_lo), .cut_hi(cut_hi), .busy(busy_b), .done(done_b),
    .ram_rd(ram_rd_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
    .freq_data(freq_data_b), .freq_valid(freq_valid_b),
    .freq_last(freq_last_b), .freq_ready(freq_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reads that were not requested return all-ones so stray pushes show up.
  always @(posedge clk)
    ram_data_a <= ram_rd_a ? {22'd0, ram_addr_a} : 32'hFFFF_FFFF;

  logic [9:0] b_addr1, b_addr2;
  logic       b_rd1, b_rd2;
  always @(posedge clk) begin
    b_rd1      <= ram_rd_b;
    b_addr1    <= ram_addr_b;
    b_rd2      <= b_rd1;
    b_addr2    <= b_addr1;
    ram_data_b <= b_rd2 ? {22'd0, b_addr2} : 32'hFFFF_FFFF;
  end

  always_comb begin
    if (sel != 0) begin
      busy = busy_b; done = done_b; ram_rd = ram_rd_b; ram_addr = ram_addr_b;
      freq_valid = freq_valid_b; freq_last = freq_last_b; freq_data = freq_data_b;
    end else begin
      busy = busy_a; done = done_a; ram_rd = ram_rd_a; ram_addr = ram_addr_a;
      freq_valid = freq_valid_a; freq_last = freq_last_a; freq_data = freq_data_a;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] exp_beat(input int k, input logic [1:0] m,
                                           input int lo, input int hi);
    int f;
    bit pass;
    f = (k <= N/2) ? k : N - k;
    case (m)
      2'b00:   pass = 1'b1;
      2'b01:   pass = (f <= lo);
      2'b10:   pass = (f >= hi);
      default: pass = (f >= lo) && (f <= hi);
    endcase
    return pass ? 32'(k) : 32'd0;
  endfunction

  function automatic int count_nonzero();
    int n = 0;
    for (int k = 0; k < N; k++) if (got[k] != 32'd0) n++;
    return n;
  endfunction

  // pat: 0 = ready always high, 1 = 20-cycle stall at beat 500 then random.
  // evt: 0 = none, 1 = start pulse plus setting change at beat 300,
  //      2 = reset at beat 300 (frame aborted).
  task automatic apply_stimulus(input logic [1:0] m, input int lo, input int hi,
                                input int pat, input int evt);
    int c, beat, rd_exp, stall_left, low_run, lat;
    bit stall_started, first_seen, hold_chk, evt_done;
    logic [33:0] held;
    lat = (sel != 0) ? 3 : 1;
    beat = 0; rd_exp = 0; stall_left = 0; low_run = 0;
    stall_started = 0; first_seen = 0; hold_chk = 0; evt_done = 0; held = '0;
    for (int k = 0; k < N; k++) got[k] = 32'hDEAD_BEEF;
    @(negedge clk);
    mode = m; cut_lo = 10'(lo); cut_hi = 10'(hi); freq_ready = 1'b1;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    c = 0;
    while (beat < N) begin
      @(negedge clk);
      c++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (c > 8000) begin
        check_output("frame_timeout", 64'(beat), 64'(N));
        return;
      end
      if (evt == 1 && beat == 300 && !evt_done) begin
        evt_done = 1;
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        mode = ~m; cut_lo = 10'd5; cut_hi = 10'd6;
      end
      if (evt == 2 && beat == 300) begin
        rst_n = 1'b0;
        #1;
        check_output("reset_abort",
          {busy, done, ram_rd, ram_addr, freq_valid, freq_last, freq_data}, 64'd0);
        @(negedge clk);
        #1;
        check_output("reset_hold",
          {busy, done, ram_rd, ram_addr, freq_valid, freq_last, freq_data}, 64'd0);
        rst_n = 1'b1;
        return;
      end
      if (pat == 0) begin
        freq_ready = 1'b1;
      end else begin
        if (!stall_started && beat == 500) begin
          stall_started = 1;
          stall_left = 20;
        end
        if (stall_left > 0) begin
          freq_ready = 1'b0;
          stall_left--;
          low_run++;
        end else if (stall_started) begin
          freq_ready = 1'($urandom_range(0, 1));
        end else begin
          freq_ready = 1'b1;
        end
      end
      #1;
      if (c == 1)
        check_output("start_response", {busy, ram_rd, ram_addr}, {1'b1, 1'b1, 10'd0});
      if (pat != 0 && !freq_ready && low_run == lat + 2)
        check_output("read_stall", 64'(ram_rd), 64'd0);
      if (ram_rd) begin
        check_output("read_addr", 64'(ram_addr), 64'(rd_exp));
        rd_exp++;
      end
      if (freq_valid && !first_seen) begin
        first_seen = 1;
        check_output("first_valid_cycle", 64'(c), 64'(2 + lat));
      end
      if (hold_chk)
        check_output("stall_hold", {freq_valid, freq_last, freq_data}, held);
      hold_chk = 0;
      if (freq_valid && freq_ready) begin
        check_output("beat_data", {freq_last, freq_data},
                     {(beat == N-1), exp_beat(beat, m, lo, hi)});
        got[beat] = freq_data;
        if (pat == 0 && beat == N-1)
          check_output("last_cycle", 64'(c), 64'(1 + lat + N));
        beat++;
      end else if (freq_valid) begin
        hold_chk = 1;
        held = {1'b1, freq_last, freq_data};
      end
    end
    @(negedge clk);
    #1;
    check_output("done_pulse", {done, busy}, 2'b10);
    @(negedge clk);
    #1;
    check_output("done_clear", {done, busy, ram_rd}, 3'b000);
    check_output("addr_hold", 64'(ram_addr), 64'(N-1));
  endtask

  initial begin
    vectors = 0; miscompares = 0; sel = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    mode = 2'b00; cut_lo = '0; cut_hi = '0; freq_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_a",
      {busy_a, done_a, ram_rd_a, ram_addr_a, freq_valid_a, freq_last_a, freq_data_a}, 64'd0);
    check_output("reset_b",
      {busy_b, done_b, ram_rd_b, ram_addr_b, freq_valid_b, freq_last_b, freq_data_b}, 64'd0);
    rst_n = 1'b1;

    // Low-pass, cut_lo = 9
    apply_stimulus(2'b01, 9, 0, 0, 0);
    check_output("lp_bin9",    64'(got[9]),    64'd9);
    check_output("lp_bin10",   64'(got[10]),   64'd0);
    check_output("lp_bin1014", 64'(got[1014]), 64'd0);
    check_output("lp_bin1015", 64'(got[1015]), 64'd1015);
    check_output("lp_nonzero", 64'(count_nonzero()), 64'd18);

    // Band-pass 100..200, then an inverted band
    apply_stimulus(2'b11, 100, 200, 0, 0);
    check_output("bp_bin99",  64'(got[99]),  64'd0);
    check_output("bp_bin100", 64'(got[100]), 64'd100);
    check_output("bp_bin200", 64'(got[200]), 64'd200);
    check_output("bp_bin201", 64'(got[201]), 64'd0);
    check_output("bp_bin823", 64'(got[823]), 64'd0);
    check_output("bp_bin824", 64'(got[824]), 64'd824);
    check_output("bp_bin924", 64'(got[924]), 64'd924);
    check_output("bp_bin925", 64'(got[925]), 64'd0);
    check_output("bp_nonzero", 64'(count_nonzero()), 64'd202);
    apply_stimulus(2'b11, 300, 200, 0, 0);
    check_output("bp_inverted_nonzero", 64'(count_nonzero()), 64'd0);

    // High-pass at the Nyquist bin, then pass-all
    apply_stimulus(2'b10, 0, 512, 0, 0);
    check_output("hp_bin511", 64'(got[511]), 64'd0);
    check_output("hp_bin512", 64'(got[512]), 64'd512);
    check_output("hp_bin513", 64'(got[513]), 64'd0);
    check_output("hp_nonzero", 64'(count_nonzero()), 64'd1);
    apply_stimulus(2'b00, 0, 0, 0, 0);
    check_output("pa_bin777", 64'(got[777]), 64'd777);
    check_output("pa_nonzero", 64'(count_nonzero()), 64'd1023);

    // Backpressure
    apply_stimulus(2'b00, 0, 0, 1, 0);
    check_output("bkp_nonzero", 64'(count_nonzero()), 64'd1023);

    // Ignored start with mid-frame setting change, then reset abort and restart
    apply_stimulus(2'b00, 0, 0, 0, 1);
    check_output("ign_nonzero", 64'(count_nonzero()), 64'd1023);
    apply_stimulus(2'b00, 0, 0, 0, 2);
    apply_stimulus(2'b01, 50, 0, 0, 0);
    check_output("restart_nonzero", 64'(count_nonzero()), 64'd100);

    // RAM_LAT = 3
    sel = 1;
    apply_stimulus(2'b11, 100, 200, 1, 0);
    check_output("lat3_bkp_nonzero", 64'(count_nonzero()), 64'd202);
    apply_stimulus(2'b00, 0, 0, 0, 0);
    check_output("lat3_pa_bin1023", 64'(got[1023]), 64'd1023);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
